// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: sequential PC generator, 1-cycle imem
// response capture, and a DEPTH-entry {pc, inst} queue drained by ID.
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [XLEN-1:0]            imem_rdata,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_inst,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [OW:0] DEPTH_W = (OW + 1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   head_q;
  logic [AW-1:0]   tail_q;
  logic [OW-1:0]   count_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] infl_pc_q;
  logic            infl_q;

  logic [OW:0]     credit;
  logic            push;
  logic            pop;
  logic            unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  // Outstanding request reserves a slot so a response never meets a full queue
  assign credit    = {1'b0, count_q} + {{OW{1'b0}}, infl_q};
  assign imem_req  = !rst && !redirect && (credit < DEPTH_W);
  assign imem_addr = fetch_pc_q;

  assign out_valid = (count_q != '0);
  assign occupancy = count_q;
  assign out_pc    = out_valid ? mem_q[head_q].pc   : '0;
  assign out_inst  = out_valid ? mem_q[head_q].inst : '0;

  assign push = infl_q && !redirect;
  assign pop  = out_valid && out_ready && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      infl_q     <= 1'b0;
      infl_pc_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else if (redirect) begin
      fetch_pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
      infl_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      infl_q <= imem_req;
      if (imem_req) begin
        infl_pc_q  <= fetch_pc_q;
        fetch_pc_q <= fetch_pc_q + XLEN'(4);
      end
      if (push) tail_q <= tail_q + AW'(1);
      if (pop)  head_q <= head_q + AW'(1);
      unique case (1'b1)
        push && !pop: count_q <= count_q + OW'(1);
        pop && !push: count_q <= count_q - OW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[tail_q] <= '{pc: infl_pc_q, inst: imem_rdata};
    end
  end

endmodule
